// File: rtl/seed_stream_arbiter_if.sv
// Seed stream bus: per-requester request/grant plus the word stream handshake.
// The arbiter takes the master modport, the consumer side takes slave.
interface seed_stream_arbiter_if #(
  parameter int NREQ   = 2,
  parameter int WORD_W = 64
);
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   gnt;
  logic [WORD_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              busy;

  modport master (
    input  req,
    input  out_ready,
    output gnt,
    output out_data,
    output out_valid,
    output out_last,
    output busy
  );

  modport slave (
    output req,
    output out_ready,
    input  gnt,
    input  out_data,
    input  out_valid,
    input  out_last,
    input  busy
  );
endinterface

// File: rtl/seed_stream_arbiter.sv
// Round-robin seed sharer: snapshots seed_in on grant, streams it MSB-first.
// Optional SEED_STREAM_USECOUNT_EN adds a saturating completed-transfer count.
module seed_stream_arbiter #(
  parameter int NREQ       = 2,
  parameter int SEED_BYTES = 32,
  parameter int WORD_W     = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SEED_BYTES*8-1:0] seed_in,
`ifdef SEED_STREAM_USECOUNT_EN
  output logic [7:0]              use_count,
`endif
  seed_stream_arbiter_if.master   bus
);

  localparam int SW = SEED_BYTES * 8;
  localparam int NW = SW / WORD_W;
  localparam int CW = (NW > 1) ? $clog2(NW) : 1;
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  state_t            state;
  logic [SW-1:0]     seed_q;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     nxt;
  logic [IW-1:0]     last_gnt;
  logic [IW-1:0]     pick;
  logic [IW-1:0]     cand;
  logic              any;
  logic              hs;
  logic [WORD_W-1:0] words [NW];

  for (genvar k = 0; k < NW; k++) begin : g_word
    assign words[k] = seed_q[SW-1-k*WORD_W -: WORD_W];
  end

  assign nxt = cnt + CW'(1);
  assign hs  = bus.out_valid & bus.out_ready;

  // Search upward from the requester after the last winner, wrapping.
  always_comb begin
    pick = '0;
    cand = '0;
    any  = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = IW'((int'(last_gnt) + i) % NREQ);
      if (!any && bus.req[cand]) begin
        any  = 1'b1;
        pick = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      seed_q        <= '0;
      cnt           <= '0;
      last_gnt      <= IW'(NREQ - 1);
      bus.gnt       <= '0;
      bus.out_data  <= '0;
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
      bus.busy      <= 1'b0;
`ifdef SEED_STREAM_USECOUNT_EN
      use_count     <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (any) begin
            state         <= STREAM;
            seed_q        <= seed_in;
            cnt           <= '0;
            last_gnt      <= pick;
            bus.gnt       <= NREQ'(1) << pick;
            bus.out_data  <= seed_in[SW-1 -: WORD_W];
            bus.out_valid <= 1'b1;
            bus.out_last  <= (NW == 1);
            bus.busy      <= 1'b1;
          end
        end
        STREAM: begin
          if (hs) begin
            if (bus.out_last) begin
              state         <= IDLE;
              cnt           <= '0;
              bus.gnt       <= '0;
              bus.out_data  <= '0;
              bus.out_valid <= 1'b0;
              bus.out_last  <= 1'b0;
              bus.busy      <= 1'b0;
`ifdef SEED_STREAM_USECOUNT_EN
              if (use_count != 8'hFF)
                use_count <= use_count + 8'd1;
`endif
            end else begin
              cnt          <= nxt;
              bus.out_data <= words[nxt];
              bus.out_last <= (nxt == CW'(NW - 1));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/seed_stream_arbiter.md
# seed_stream_arbiter

Shares the 256-bit constant seed from `randombytes` among several consumers, such as the key-generation SHAKE absorber and a future signing-nonce path. A round-robin arbiter grants one requester at a time. On grant the block snapshots the seed and streams it to the winner as fixed-width words over a valid/ready handshake. It sits between `randombytes` and the hash-input muxes.

## Interface
- `NREQ`, default 2: number of requesters, 2..8.
- `SEED_BYTES`, default 32: seed length in bytes; must equal the `randombytes` `in_len`.
- `WORD_W`, default 64: output word width. SEED_BYTES*8 must be a multiple of WORD_W.
- `clk`  in  1  — sole clock, rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `seed_in`  in  SEED_BYTES*8  — seed from `randombytes`; first byte in the MSBs.
- `req`  in  NREQ  — per-requester request levels.
- `gnt`  out  NREQ  — one-hot grant, held for the whole transfer.
- `out_data`  out  WORD_W  — current seed word.
- `out_valid`  out  1  — `out_data` is valid.
- `out_ready`  in  1  — the granted consumer accepts the word.
- `out_last`  out  1  — the current word is the final word of the seed.
- `busy`  out  1  — a transfer is in progress.

## Operation
- NW = SEED_BYTES*8/WORD_W words per transfer (default 4). Word k = `seed_in[SEED_BYTES*8-1-k*WORD_W -: WORD_W]`, so the stream is MSB-first.
- FSM has two states, IDLE and STREAM.
- IDLE:
  - If any `req` bit is high, pick the first set bit searching upward (with wrap) from `last_gnt+1`.
  - Register the one-hot `gnt`, load `seed_in` into the internal seed register, clear the word counter, set `last_gnt` to the winner, and go to STREAM.
- STREAM:
  - `out_valid`=1, `busy`=1, `out_data` = word[cnt], `out_last` = (cnt==NW-1).
  - Each cycle with `out_valid` & `out_ready` high, cnt increments.
  - A handshake with `out_last` high returns the FSM to IDLE and clears `gnt`.
- A transfer, once granted, always completes. `req` is ignored during STREAM; dropping it mid-transfer neither aborts the transfer nor changes `gnt`.
- Changes on `seed_in` during STREAM do not affect the word sequence already in flight (snapshot semantics).
- In IDLE, `out_data`, `out_valid`, `out_last`, `busy` and `gnt` are all 0.

## Timing
- Reset values:
  - FSM = IDLE; `gnt`, `out_data`, `out_valid`, `out_last`, `busy` = 0.
  - cnt = 0; `last_gnt` = NREQ-1, so requester 0 wins first.
- Grant latency: `req` high at edge N gives `gnt` and `out_valid` high after edge N+1. All outputs are registered.
- With `out_ready` held high, words 0..NW-1 occupy NW consecutive cycles, and `gnt` drops one cycle after the last word.
- Minimum gap between transfers is one IDLE cycle. The next grant appears two cycles after the last handshake.
- `out_ready` low stalls the stream: `out_data`, `out_valid` and `out_last` hold unchanged.
- Reset asserted mid-transfer immediately forces all reset values. The aborted transfer is not resumed.
- Simultaneous requests are resolved only by round-robin order; no requester is served twice while another is pending.

## Configuration
- `SEED_STREAM_USECOUNT_EN`:
  - When defined, adds output `use_count` [7:0], reset 0. It increments on every completed transfer (last-word handshake) and saturates at 255.
  - When undefined, the port and its counter are absent.

## Test plan
- **Single transfer:** reset, then `req`=01, `out_ready`=1, default seed → `gnt`=01. Words are 0x06FE254AEA8968B7, 0x9C46EB6D23F970F2, 0xEF28EE4CEB6FD2DD, 0x8D8538D4F060B96E, with `out_last` only on the 4th. `gnt`=00 on the following cycle.
- **Round-robin:** `req`=11 held → grants 01, 10, 01, 10. Exactly one IDLE cycle separates transfers.
- **Backpressure:** `out_ready` low for 3 cycles after word 1 → word 1 (0x9C46EB6D23F970F2) is held stable for those 3 cycles. The remaining words arrive in order.
- **Request drop:** deassert `req[0]` after word 0 → all 4 words are still delivered and `gnt`=01 holds until the last word.
- **Reset mid-transfer:** assert `rst` during word 2 → all outputs are 0 in the same cycle. After release with `req`=10, requester 1 is granted and word 0 is 0x06FE254AEA8968B7.
- **Counter (with `SEED_STREAM_USECOUNT_EN` defined):** 300 back-to-back transfers → `use_count` reads 255, no wrap.
